// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: a pc register drives a combinational instruction
// memory, and fetched words queue in a 2-entry prefetch FIFO for the decoder.
module instruction_fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                MEM_DEPTH   = 128,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // MEM_DEPTH is a power of two, so masking implements "mod MEM_DEPTH"
  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [1:0]        count_r;
  logic [1:0]        count_nxt_s;
  logic [DATA_W-1:0] word_r [0:1];
  logic [ADDR_W-1:0] wpc_r  [0:1];

  logic start_take_s;
  logic branch_take_s;
  logic fetch_s;
  logic halt_hit_s;
  logic push_s;
  logic pop_s;
  logic flush_s;

  // Control decode; a taken branch overrides any same-cycle push, pop or halt
  always_comb begin
    start_take_s  = start && ((state_r == ST_IDLE) || (state_r == ST_HALTED));
    branch_take_s = branch_valid && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    fetch_s       = (state_r == ST_RUN) && (count_r < 2'd2);
    halt_hit_s    = fetch_s && (imem_data == HALT_OPCODE);
    push_s        = fetch_s && !halt_hit_s && !branch_take_s;
    pop_s         = (count_r != 2'd0) && instr_ready && !branch_take_s;
    flush_s       = start_take_s || branch_take_s;
  end

  // Next occupancy of the prefetch buffer
  always_comb begin
    count_nxt_s = count_r;
    if (flush_s) begin
      count_nxt_s = 2'd0;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start_take_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (branch_take_s) begin
          state_nxt_s = ST_RUN;
        end else if (halt_hit_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (branch_take_s) begin
          state_nxt_s = ST_RUN;
        end else if (count_nxt_s == 2'd0) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Program counter: redirects load a masked target, pushes advance with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (start_take_s) begin
      pc_r <= start_addr & PC_MASK;
    end else if (branch_take_s) begin
      pc_r <= branch_addr & PC_MASK;
    end else if (push_s) begin
      pc_r <= (pc_r + {{(ADDR_W-1){1'b0}}, 1'b1}) & PC_MASK;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Prefetch FIFO; entry 0 is always the head presented to the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      word_r[0] <= {DATA_W{1'b0}};
      word_r[1] <= {DATA_W{1'b0}};
      wpc_r[0]  <= {ADDR_W{1'b0}};
      wpc_r[1]  <= {ADDR_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      if (flush_s) begin
        word_r[0] <= {DATA_W{1'b0}};
        word_r[1] <= {DATA_W{1'b0}};
        wpc_r[0]  <= {ADDR_W{1'b0}};
        wpc_r[1]  <= {ADDR_W{1'b0}};
      end else begin
        case ({push_s, pop_s})
          2'b10: begin
            if (count_r == 2'd0) begin
              word_r[0] <= imem_data;
              wpc_r[0]  <= pc_r;
            end else begin
              word_r[1] <= imem_data;
              wpc_r[1]  <= pc_r;
            end
          end
          2'b01: begin
            word_r[0] <= word_r[1];
            wpc_r[0]  <= wpc_r[1];
          end
          2'b11: begin
            // Push only happens below full, so count is 1 here: new word becomes head
            word_r[0] <= imem_data;
            wpc_r[0]  <= pc_r;
          end
          default: begin
            word_r[0] <= word_r[0];
            wpc_r[0]  <= wpc_r[0];
          end
        endcase
      end
    end
  end

  assign imem_addr   = pc_r;
  assign imem_en     = fetch_s;
  assign instr_valid = (count_r != 2'd0);
  assign instr_data  = word_r[0];
  assign instr_pc    = wpc_r[0];
  assign busy        = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign halted      = (state_r == ST_HALTED);

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 8: instruction address width.
REQ-002 Parameter DATA_W, 8: instruction word width.
REQ-003 Parameter MEM_DEPTH, 128: instruction memory depth; SHALL be a power of two, at most 2^ADDR_W.
REQ-004 Parameter HALT_OPCODE, 8'hFF: instruction word that stops fetching.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin fetching at start_addr (honoured in IDLE/HALTED only).
REQ-008 start_addr  input  ADDR_W  first fetch address.
REQ-009 branch_valid  input  1  redirect fetch (honoured in RUN/DRAIN only).
REQ-010 branch_addr  input  ADDR_W  redirect target.
REQ-011 imem_addr  output  ADDR_W  instruction memory address; always equals pc.
REQ-012 imem_en  output  1  instruction memory read enable.
REQ-013 imem_data  input  DATA_W  combinational read data, valid in the same cycle imem_en=1.
REQ-014 instr_valid  output  1  decoder-side valid; high when the prefetch buffer is non-empty.
REQ-015 instr_data  output  DATA_W  buffer head instruction word.
REQ-016 instr_pc  output  ADDR_W  address the head word was fetched from.
REQ-017 instr_ready  input  1  decoder accepts the head word when high together with instr_valid.
REQ-018 busy  output  1  high in RUN or DRAIN.
REQ-019 halted  output  1  high in HALTED.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, DRAIN and HALTED. It SHALL hold a pc register and a 2-entry FIFO prefetch buffer storing {word, pc} pairs, with an occupancy count of 0..2.
REQ-021 imem_en SHALL be 1 iff state=RUN and count<2. A fetch SHALL never be issued into a full buffer, even if a pop occurs in the same cycle.
REQ-022 On a RUN cycle with imem_en=1 and imem_data!=HALT_OPCODE, the block SHALL push {imem_data, pc} at the clock edge and set pc to pc+1, wrapping MEM_DEPTH-1 to 0.
REQ-023 On a RUN cycle with imem_en=1 and imem_data==HALT_OPCODE, the block SHALL push nothing, keep pc unchanged and go to DRAIN.
REQ-024 DRAIN SHALL keep imem_en=0. It SHALL go to HALTED at the edge where count becomes 0, or immediately if count is already 0.
REQ-025 A pop SHALL occur at an edge where instr_valid=1 and instr_ready=1. Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-026 instr_data and instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-027 start in IDLE or HALTED SHALL flush the buffer, load pc with start_addr mod MEM_DEPTH, and enter RUN. start in RUN or DRAIN SHALL be ignored.
REQ-028 branch_valid in RUN or DRAIN SHALL flush the buffer, load pc with branch_addr mod MEM_DEPTH, and enter RUN. Any same-cycle fetch result SHALL be discarded.
REQ-029 branch_valid SHALL take priority over same-cycle push, pop and HALT detection. branch_valid in IDLE or HALTED SHALL be ignored.
REQ-030 Latency: start sampled at edge E0 -> imem_en=1 in the cycle after E0 -> instr_valid=1 after E1. Steady throughput with instr_ready held high SHALL be 1 word per cycle.
REQ-031 Any words remaining after a flush SHALL never be presented again.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, pc=0, count=0, all buffer entries=0.
REQ-033 Resulting output values during reset: imem_en=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0, halted=0.
REQ-034 start and branch_valid SHALL be ignored while rst_n=0. Reset asserted mid-RUN SHALL drop all buffered words.

Verification
REQ-035 mem[0..3]=4, mem[4]=FF, start_addr=0, instr_ready=1 -> words 4 with instr_pc 0,1,2,3 on consecutive cycles; then imem_en=0, busy=0, halted=1.
REQ-036 Same program with instr_ready=0 -> after two fetches: imem_en=0, pc=2, instr_pc=0 held stable; ready raised -> instr_pc 0,1,2,3 in order, with no loss or duplication.
REQ-037 Buffer full (instr_pc 0,1), branch_valid with branch_addr=0x10 -> instr_valid=0 the next cycle, then instr_pc=0x10; words 0 and 1 are never presented again.
REQ-038 start_addr=127, MEM_DEPTH=128, no HALT -> instr_pc sequence 127, 0, 1.
REQ-039 rst_n pulled low between edges during RUN with count=2 -> all outputs at reset values before the next edge; after release, the block stays in IDLE until start.
REQ-040 start pulsed in RUN -> no effect on pc or buffer; start pulsed in HALTED with start_addr=2 -> RUN, first instr_pc=2.
